// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: instruction width,
// canonical NOP encoding and the fetch-stage state encoding.
package riscv_pkg;

    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage. Keeps the PC, issues one word request at a time to
// instruction memory and hands each returned instruction, tagged with its PC,
// to decode over a valid/ready handshake. A redirect replaces the PC and kills
// any held or in-flight instruction; a response belonging to a killed request
// is swallowed in DRAIN. Misaligned PCs are never fetched: a NOP is presented
// with the misaligned flag so decode can raise the trap.
module fetch
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [ILEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [ILEN-1:0] inst_pc,
    output logic            misaligned
);

    fetch_state_t    state_r;
    fetch_state_t    state_n_s;
    logic [ILEN-1:0] pc_r;
    logic [ILEN-1:0] pc_n_s;
    logic [ILEN-1:0] inst_r;
    logic [ILEN-1:0] inst_pc_r;
    logic            misaligned_r;
    logic            inst_valid_r;

    logic            pc_aligned_s;
    logic            load_s;
    logic [ILEN-1:0] load_inst_s;
    logic            load_mis_s;

    // Memory request decodes only from registered state and PC, so there is
    // no combinational path from imem_ready or inst_ready to the request.
    assign pc_aligned_s = (pc_r[1:0] == 2'b00);
    assign imem_req     = (state_r == REQ) && pc_aligned_s;
    assign imem_addr    = {pc_r[ILEN-1:2], 2'b00};

    assign inst_valid   = inst_valid_r;
    assign inst         = inst_r;
    assign inst_pc      = inst_pc_r;
    assign misaligned   = misaligned_r;

    // Next-state, next-PC and instruction-capture decode; redirect overrides
    // every other event but must still track whether a request is in flight.
    always_comb begin
        state_n_s   = state_r;
        pc_n_s      = pc_r;
        load_s      = 1'b0;
        load_inst_s = NOP_INST;
        load_mis_s  = 1'b0;
        if (redirect) begin
            pc_n_s = redirect_pc;
            case (state_r)
                IDLE:    state_n_s = REQ;
                HOLD:    state_n_s = REQ;
                REQ:     state_n_s = (imem_req && imem_ready) ? DRAIN : REQ;
                WAIT:    state_n_s = imem_rvalid ? REQ : DRAIN;
                DRAIN:   state_n_s = imem_rvalid ? REQ : DRAIN;
                default: state_n_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = REQ;
                end
                REQ: begin
                    if (!pc_aligned_s) begin
                        load_s      = 1'b1;
                        load_inst_s = NOP_INST;
                        load_mis_s  = 1'b1;
                        state_n_s   = HOLD;
                    end else if (imem_ready) begin
                        state_n_s = WAIT;
                    end else begin
                        state_n_s = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        load_s      = 1'b1;
                        load_inst_s = imem_rdata;
                        load_mis_s  = 1'b0;
                        state_n_s   = HOLD;
                    end else begin
                        state_n_s = WAIT;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        // Low bits are kept so a misaligned PC stays visible.
                        pc_n_s    = pc_r + 32'd4;
                        state_n_s = REQ;
                    end else begin
                        state_n_s = HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_n_s = REQ;
                    end else begin
                        state_n_s = DRAIN;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // State, PC and registered decode-side outputs; inst_valid is high exactly
    // while the FSM sits in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            inst_valid_r <= 1'b0;
            inst_r       <= NOP_INST;
            inst_pc_r    <= RESET_PC;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            pc_r         <= pc_n_s;
            inst_valid_r <= (state_n_s == HOLD);
            if (load_s) begin
                inst_r       <= load_inst_s;
                inst_pc_r    <= pc_r;
                misaligned_r <= load_mis_s;
            end else begin
                inst_r       <= inst_r;
                inst_pc_r    <= inst_pc_r;
                misaligned_r <= misaligned_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage. A small memory responder inside the
// cycle task answers each accepted request one cycle later (unless held back)
// with a word derived from the address, so expected instructions are known.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned;

    int pass_cnt;
    int chk_cnt;
    int req_cnt;
    int xfer_cnt;
    int req_before;
    int xfer_before;

    logic        mem_ready;
    logic        hold_resp;
    logic        resp_pend;
    logic [31:0] resp_data;

    fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return {16'hA5A5, addr[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive memory inputs for this cycle, advance past the edge,
    // then update the responder model. Outputs are sampled 1ns after the edge.
    task automatic tick();
        logic accept;
        logic delivered;
        imem_ready  = mem_ready;
        imem_rvalid = resp_pend && !hold_resp;
        imem_rdata  = resp_data;
        delivered   = imem_rvalid;
        accept      = (imem_req === 1'b1) && imem_ready;
        if (accept) req_cnt++;
        if ((inst_valid === 1'b1) && inst_ready) xfer_cnt++;
        @(posedge clk);
        #1;
        if (delivered) resp_pend = 1'b0;
        if (accept) begin
            resp_pend = 1'b1;
            resp_data = word_of(imem_addr_q);
        end
    endtask

    // Address of the request presented in the cycle just before the edge.
    logic [31:0] imem_addr_q;
    always @(negedge clk) imem_addr_q = imem_addr;

    initial begin
        pass_cnt = 0; chk_cnt = 0; req_cnt = 0; xfer_cnt = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        mem_ready = 1'b1; hold_resp = 1'b0; resp_pend = 1'b0; resp_data = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        tick(); tick();

        // Reset values
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'h0000_0013);
        check_eq("rst_inst_pc", inst_pc, 32'h0000_0100);
        check_eq("rst_mis", {31'd0, misaligned}, 32'd0);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0000_0100);

        // Streaming: one instruction every three cycles
        rst = 1'b0;
        check_eq("cyc0_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("cyc1_req", {31'd0, imem_req}, 32'd1);
        check_eq("cyc1_addr", imem_addr, 32'h0000_0100);
        tick(); tick();
        check_eq("s0_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("s0_pc", inst_pc, 32'h0000_0100);
        check_eq("s0_inst", inst, word_of(32'h0000_0100));
        tick(); tick(); tick();
        check_eq("s1_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("s1_pc", inst_pc, 32'h0000_0104);
        check_eq("s1_inst", inst, word_of(32'h0000_0104));
        tick(); tick(); tick();
        check_eq("s2_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("s2_pc", inst_pc, 32'h0000_0108);
        check_eq("s2_inst", inst, word_of(32'h0000_0108));
        check_eq("s_xfers", xfer_cnt, 32'd2);

        // Backpressure in HOLD
        inst_ready = 1'b0;
        req_before = req_cnt;
        for (int i = 0; i < 5; i++) tick();
        check_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("bp_pc", inst_pc, 32'h0000_0108);
        check_eq("bp_inst", inst, word_of(32'h0000_0108));
        check_eq("bp_req", {31'd0, imem_req}, 32'd0);
        check_eq("bp_reqcnt", req_cnt, req_before);
        inst_ready = 1'b1;
        tick();
        check_eq("bp_next_addr", imem_addr, 32'h0000_010C);
        check_eq("bp_next_req", {31'd0, imem_req}, 32'd1);

        // Redirect in WAIT, stale response two cycles later
        tick();
        hold_resp = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check_eq("rw_req", {31'd0, imem_req}, 32'd0);
        check_eq("rw_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("rw_drain_req", {31'd0, imem_req}, 32'd0);
        hold_resp = 1'b0; resp_data = 32'hDEAD_BEEF;
        tick();
        check_eq("rw_req2", {31'd0, imem_req}, 32'd1);
        check_eq("rw_addr", imem_addr, 32'h0000_0200);
        tick(); tick();
        check_eq("rw_valid2", {31'd0, inst_valid}, 32'd1);
        check_eq("rw_pc", inst_pc, 32'h0000_0200);
        check_eq("rw_inst", inst, word_of(32'h0000_0200));

        // Redirect in HOLD together with a transfer
        xfer_before = xfer_cnt;
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        check_eq("rh_xfer", xfer_cnt - xfer_before, 32'd1);
        check_eq("rh_addr", imem_addr, 32'h0000_0300);
        check_eq("rh_req", {31'd0, imem_req}, 32'd1);
        check_eq("rh_valid", {31'd0, inst_valid}, 32'd0);

        // Misaligned redirect target
        mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0402;
        tick();
        redirect = 1'b0; mem_ready = 1'b1;
        req_before = req_cnt;
        check_eq("mis_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("mis_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("mis_flag", {31'd0, misaligned}, 32'd1);
        check_eq("mis_inst", inst, 32'h0000_0013);
        check_eq("mis_pc", inst_pc, 32'h0000_0402);
        check_eq("mis_reqcnt", req_cnt, req_before);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check_eq("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        check_eq("wr_pc", inst_pc, 32'hFFFF_FFFC);
        check_eq("wr_mis", {31'd0, misaligned}, 32'd0);
        check_eq("wr_inst", inst, word_of(32'hFFFF_FFFC));
        tick();
        check_eq("wr_next_addr", imem_addr, 32'h0000_0000);

        // Reset while waiting; the late response must be ignored
        tick();
        hold_resp = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rr_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rr_req", {31'd0, imem_req}, 32'd0);
        tick();
        mem_ready = 1'b0; hold_resp = 1'b0; resp_data = 32'hDEAD_BEEF;
        tick();
        check_eq("rr_stale_req", {31'd0, imem_req}, 32'd1);
        check_eq("rr_stale_addr", imem_addr, 32'h0000_0100);
        check_eq("rr_stale_valid", {31'd0, inst_valid}, 32'd0);
        mem_ready = 1'b1;
        tick(); tick();
        check_eq("rr_pc", inst_pc, 32'h0000_0100);
        check_eq("rr_inst", inst, word_of(32'h0000_0100));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the RISC-V core, directly upstream of the instruction decoder. Holds the PC, issues one word request at a time to instruction memory, and presents each returned 32-bit instruction with its PC to decode over a valid/ready handshake. Accepts PC redirects from branch/jump resolution, discarding in-flight or held instructions. Flags misaligned redirect targets instead of fetching them.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset (must be 4-byte aligned)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  request valid; address in imem_addr
- imem_addr  out  32  word address of request, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready = accepted)
- imem_rvalid  in  1  response data valid; earliest one cycle after acceptance
- imem_rdata  in  32  response instruction word
- redirect  in  1  load new PC, kill everything younger
- redirect_pc  in  32  redirect target
- inst_valid  out  1  inst/inst_pc/misaligned valid to decode
- inst_ready  in  1  decode consumes this cycle (inst_valid & inst_ready = transfer)
- inst  out  32  fetched instruction
- inst_pc  out  32  PC of inst
- misaligned  out  1  inst_pc has bits [1:0] != 0; inst is NOP, not fetched

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD. Reset state IDLE; IDLE -> REQ unconditionally.
- REQ: imem_req=1, imem_addr={pc[31:2],2'b00}. On imem_ready -> WAIT. If pc[1:0]!=0, no request: load inst=NOP, inst_pc=pc, misaligned=1 -> HOLD.
- WAIT: on imem_rvalid register inst=imem_rdata, inst_pc=pc, misaligned=0 -> HOLD.
- HOLD: inst_valid=1; outputs stable until transfer. On inst_ready: pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) -> REQ.
- DRAIN: one request outstanding whose response is stale; on imem_rvalid discard data -> REQ.
- Redirect has priority over every other event in every state: pc <= redirect_pc, inst_valid deasserts next cycle, held instruction dropped, no PC increment.
  - IDLE/HOLD/REQ without imem_ready -> REQ.
  - REQ with imem_ready same cycle -> DRAIN (request was accepted).
  - WAIT without imem_rvalid -> DRAIN; WAIT with imem_rvalid -> REQ, data discarded.
  - DRAIN without imem_rvalid -> stay DRAIN; with imem_rvalid -> REQ.
  - HOLD with inst_ready same cycle: transfer still counts for decode, pc takes redirect_pc (not +4).
- At most one outstanding memory request; imem_rvalid outside WAIT/DRAIN ignored.
- Misaligned fetch is reported once per PC; decode/trap logic must redirect; without redirect, consumption advances pc by 4 preserving low bits.

## Timing
- Reset values: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013, inst_pc=RESET_PC, misaligned=0.
- rst asserted in any state (incl. WAIT/DRAIN) returns to IDLE next edge; a pending memory response arriving after reset is ignored until a new request is accepted.
- inst, inst_pc, misaligned, inst_valid are registered; imem_req/imem_addr decode from registered state/pc only (no comb path from imem_ready/inst_ready).
- Best-case throughput: accept in cycle N, rvalid N+1, inst_valid N+2, transfer N+2, next req N+3 → one instruction per 3 cycles.
- First request: imem_req high in cycle 1 after the cycle rst falls (cycle 0).
- imem_addr held stable while imem_req=1 and imem_ready=0 unless redirect.

## Structure
- Shared package riscv_pkg: NOP_INST = 32'h0000_0013, fetch_state_t enum (IDLE, REQ, WAIT, DRAIN, HOLD), ILEN=32.
- Single flat module; no sub-module warranted.

## Test plan
- Reset, RESET_PC=32'h100, memory ready always, rvalid 1 cycle later, inst_ready=1 -> inst_pc sequence 0x100,0x104,0x108 with matching rdata, one transfer per 3 cycles.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0, no extra requests; release -> pc advances by exactly 4.
- Redirect to 0x200 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data discarded (DRAIN), next request addr 0x200, inst_pc 0x200.
- Redirect to 0x300 in HOLD with inst_ready=1 same cycle -> transfer of old inst, next imem_addr 0x300 (not old pc+4).
- Redirect to 0x402 -> no imem_req, inst_valid=1, misaligned=1, inst=0x00000013, inst_pc=0x402.
- PC 0xFFFF_FFFC consumed -> next imem_addr 0x0000_0000; rst asserted in WAIT -> next cycle IDLE, inst_valid=0, subsequent stale rvalid ignored.
